// File: rtl/router_pkg.sv
// Shared router definitions: default widths, entry layout and a clog2 helper.
package router_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned LEN_LSB_DEF = 2;
    // Stored FIFO entry is {header flag, data}.
    localparam int unsigned ENTRY_W_DEF = DATA_W_DEF + 1;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned x;
        res = 0;
        x   = (value > 0) ? value - 1 : 0;
        while (x > 0) begin
            res = res + 1;
            x   = x >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port RAM: one synchronous write port, one synchronous registered read port.
module fifo_mem_2p
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ENTRY_W_DEF,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; storage has no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; clr forces the visible output back to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet FIFO for one router output channel: header-tagged entries, occupancy flags,
// flush, sticky error flags and end-of-packet marking on the read side.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned AF_THRESH = 14,
    parameter  int unsigned LEN_LSB   = LEN_LSB_DEF,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              wr_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_eop,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [AW:0]       count,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int unsigned EW = DATA_W + 1;
    localparam int unsigned LW = DATA_W - LEN_LSB;
    localparam int unsigned RW = LW + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          valid_q;
    logic          ovf_q, udf_q;
    logic [EW-1:0] rdata;
    logic          ra, wa, flush;
    logic          rd_hdr;
    logic [LW-1:0] rd_len;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;

    assign ra    = rd_en & ~empty;
    assign wa    = wr_en & (~full | ra);
    assign flush = rst | soft_rst;

    fifo_mem_2p #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .clr   (flush),
        .we    (wa & ~flush),
        .waddr (wr_ptr_q),
        .wdata ({lfd_state, din}),
        .re    (ra & ~flush),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign rd_hdr     = rdata[DATA_W];
    assign rd_len     = rdata[DATA_W-1:LEN_LSB];
    assign dout       = rdata[DATA_W-1:0];
    assign dout_valid = valid_q;
    // The tracker consumes each word while it is presented, so eop is aligned with dout.
    assign dout_eop   = valid_q & ~rd_hdr & (rem_q == RW'(1));
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

    // Next occupancy and next remaining-length for the word currently on dout.
    always_comb begin
        count_d = count_q;
        rem_d   = rem_q;
        unique case ({wa, ra})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (valid_q) begin
            if (rd_hdr) begin
                // A header restarts the tracker even mid-packet.
                rem_d = {1'b0, rd_len} + RW'(1);
            end else if (rem_q != '0) begin
                rem_d = rem_q - RW'(1);
            end
        end
    end

    // Pointer, count, tracker and flag state; rst clears all, soft_rst keeps error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wa) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (ra) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            rem_q   <= rem_d;
            valid_q <= ra;
            if (wr_en & full & ~ra) ovf_q <= 1'b1;
            if (rd_en & empty)      udf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Bench for router_fifo_pkt: two configurations checked against a queue-based packet model.
module tb_router_fifo_pkt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, soft_rst = 1'b0, wr_en = 1'b0, lfd_state = 1'b0, rd_en = 1'b0;
    logic [15:0] din = '0;
    int          sel = 0;

    logic [7:0]  d0_dout;
    logic        d0_valid, d0_eop, d0_full, d0_empty, d0_af, d0_ovf, d0_udf;
    logic [4:0]  d0_count;
    logic [15:0] d1_dout;
    logic        d1_valid, d1_eop, d1_full, d1_empty, d1_af, d1_ovf, d1_udf;
    logic [6:0]  d1_count;

    router_fifo_pkt dut0 (
        .clk (clk), .rst (rst), .soft_rst (soft_rst & (sel == 0)),
        .wr_en (wr_en & (sel == 0)), .lfd_state (lfd_state), .din (din[7:0]),
        .rd_en (rd_en & (sel == 0)), .dout (d0_dout), .dout_valid (d0_valid),
        .dout_eop (d0_eop), .full (d0_full), .empty (d0_empty), .almost_full (d0_af),
        .count (d0_count), .ovf_err (d0_ovf), .udf_err (d0_udf)
    );

    router_fifo_pkt #(.DATA_W(16), .DEPTH(64), .AF_THRESH(60), .LEN_LSB(2)) dut1 (
        .clk (clk), .rst (rst), .soft_rst (soft_rst & (sel == 1)),
        .wr_en (wr_en & (sel == 1)), .lfd_state (lfd_state), .din (din),
        .rd_en (rd_en & (sel == 1)), .dout (d1_dout), .dout_valid (d1_valid),
        .dout_eop (d1_eop), .full (d1_full), .empty (d1_empty), .almost_full (d1_af),
        .count (d1_count), .ovf_err (d1_ovf), .udf_err (d1_udf)
    );

    logic [15:0] o_dout;
    logic [6:0]  o_count;
    logic        o_valid, o_eop, o_full, o_empty, o_af, o_ovf, o_udf;
    always_comb begin
        o_dout  = (sel == 1) ? d1_dout  : {8'h00, d0_dout};
        o_count = (sel == 1) ? d1_count : {2'b00, d0_count};
        o_valid = (sel == 1) ? d1_valid : d0_valid;
        o_eop   = (sel == 1) ? d1_eop   : d0_eop;
        o_full  = (sel == 1) ? d1_full  : d0_full;
        o_empty = (sel == 1) ? d1_empty : d0_empty;
        o_af    = (sel == 1) ? d1_af    : d0_af;
        o_ovf   = (sel == 1) ? d1_ovf   : d0_ovf;
        o_udf   = (sel == 1) ? d1_udf   : d0_udf;
    end

    // Reference model: a queue of {header, data} words plus a packet word countdown.
    logic [16:0] q[$];
    logic [15:0] m_dout;
    bit          m_valid, m_eop, m_ovf, m_udf;
    int          m_left;
    int          checks = 0, errors = 0;

    function automatic int depth_of();
        return (sel == 1) ? 64 : 16;
    endfunction

    function automatic int af_of();
        return (sel == 1) ? 60 : 14;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("dout", 32'(o_dout), 32'(m_dout));
        chk("dout_valid", 32'(o_valid), 32'(m_valid));
        if (m_valid) chk("dout_eop", 32'(o_eop), 32'(m_eop));
        chk("count", 32'(o_count), 32'(q.size()));
        chk("full", 32'(o_full), 32'(q.size() == depth_of()));
        chk("empty", 32'(o_empty), 32'(q.size() == 0));
        chk("almost_full", 32'(o_af), 32'(q.size() >= af_of()));
        chk("ovf_err", 32'(o_ovf), 32'(m_ovf));
        chk("udf_err", 32'(o_udf), 32'(m_udf));
    endtask

    task automatic do_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_dout = '0; m_valid = 0; m_eop = 0; m_ovf = 0; m_udf = 0; m_left = 0;
        compare_all();
    endtask

    task automatic cyc(input bit wr, input bit hdr, input logic [15:0] d, input bit rd,
                       input bit sr);
        logic [16:0] e;
        logic [15:0] dm;
        bit          full_m, empty_m, ra, wa;
        dm = (sel == 1) ? d : (d & 16'h00FF);
        wr_en = wr; lfd_state = hdr; din = dm; rd_en = rd; soft_rst = sr;
        @(posedge clk);
        full_m  = (q.size() == depth_of());
        empty_m = (q.size() == 0);
        if (sr) begin
            q.delete();
            m_dout = '0; m_valid = 0; m_eop = 0; m_left = 0;
        end else begin
            ra = rd && !empty_m;
            wa = wr && (!full_m || ra);
            if (wr && full_m && !ra) m_ovf = 1;
            if (rd && empty_m) m_udf = 1;
            m_valid = ra;
            m_eop   = 0;
            if (ra) begin
                e = q.pop_front();
                m_dout = e[15:0];
                if (e[16]) begin
                    m_left = int'(e[15:0] >> 2) + 1;
                end else if (m_left > 0) begin
                    m_left--;
                    m_eop = (m_left == 0);
                end
            end
            if (wa) q.push_back({hdr, dm});
        end
        #1;
        compare_all();
        wr_en = 0; rd_en = 0; soft_rst = 0; lfd_state = 0;
    endtask

    task automatic run_suite();
        int d;
        d = depth_of();
        do_rst();
        // Header len=3, three payload words, parity, then five reads.
        cyc(1, 1, 16'h000D, 0, 0);
        cyc(1, 0, 16'h00A1, 0, 0);
        cyc(1, 0, 16'h00A2, 0, 0);
        cyc(1, 0, 16'h00A3, 0, 0);
        cyc(1, 0, 16'h005C, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, '0, 1, 0);
        chk("eop_on_parity", 32'(o_eop), 32'd1);
        chk("parity_word", 32'(o_dout), 32'h5C);
        // Fill to full, then stream through the full FIFO across pointer wrap.
        for (int i = 0; i < d; i++) cyc(1, 0, 16'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 16'($urandom), 1, 0);
        chk("ovf_clear_when_streaming", 32'(o_ovf), 32'd0);
        cyc(1, 0, 16'h0077, 0, 0);
        chk("ovf_set_on_extra_write", 32'(o_ovf), 32'd1);
        // Drain, then underflow.
        for (int i = 0; i < d; i++) cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 1, 0);
        chk("udf_set", 32'(o_udf), 32'd1);
        // Flush mid-packet, then a minimal packet.
        cyc(1, 1, 16'h0010, 0, 0);
        cyc(1, 0, 16'h0011, 0, 0);
        cyc(0, 0, '0, 0, 1);
        chk("count_after_flush", 32'(o_count), 32'd0);
        cyc(1, 1, 16'h0001, 0, 0);
        cyc(1, 0, 16'h00E5, 0, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 1, 0);
        chk("eop_short_packet", 32'(o_eop), 32'd1);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 16'($urandom),
                bit'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
        end
    endtask

    initial begin
        sel = 0;
        run_suite();
        sel = 1;
        run_suite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
